ps2_keystroke_filter: RTL and testbench
=======================================

# ps2_keystroke_filter

Sits between `PS2_Controller` (raw `received_data`/`received_data_en` byte stream) and the game's reader FSM. Collapses PS/2 Set-2 scan-code sequences (make, `F0` break, `E0` extended, `E1` pause) into one event per physical key press. Suppresses typematic auto-repeat and controller status bytes. Queues key events in a small show-ahead FIFO popped by the reader, which therefore never needs byte-level debouncing.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: event queue depth; power of 2, 2..16.
- `REPEAT_SUPPRESS`, default 1: 1 = drop repeated make codes of the currently held key; 0 = enqueue every make.

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain); one clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_data_en`  in  1  one-cycle strobe; `ps2_data` valid.
- `ps2_data`  in  8  received scan-code byte.
- `clear`  in  1  synchronous flush (new level/session).
- `key_ready`  in  1  consumer accepts head event this cycle.
- `key_valid`  out  1  FIFO non-empty.
- `key_code`  out  8  head event make code; 0 when empty.
- `key_extended`  out  1  head event was `E0`-prefixed; 0 when empty.
- `key_held`  out  1  a key is currently held (make seen, break not yet).
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  queued events.
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full.

## Operation
- Decoder FSM advances only on cycles with `ps2_data_en`=1.
  - IDLE:
    - `E0` -> EXT.
    - `F0` -> BRK.
    - `E1` -> PAUSE (skip counter := 7).
    - `00`, `AA`, `FA`, `FC`, `FD`, `FE`, `FF` discarded, stay.
    - Any other byte: make event {ext=0, code}, stay.
  - EXT:
    - `F0` -> EBRK.
    - `12` or `59` (fake shift) discarded -> IDLE.
    - Other byte: make event {ext=1, code} -> IDLE.
  - BRK: byte is break code {ext=0} -> IDLE.
  - EBRK: byte is break code {ext=1} -> IDLE.
  - PAUSE: decrement counter per byte; at 0 -> IDLE. The entire 8-byte Pause sequence produces no event.
- Held-key register {held_valid, held_ext, held_code}:
  - Make event:
    - If `REPEAT_SUPPRESS`=1 and held_valid and {ext,code} equals held, the event is dropped.
    - Otherwise the event is pushed to the FIFO and held := {1, ext, code}. The last pressed key wins (rollover).
  - Break matching held: held_valid := 0.
  - Break not matching held: ignored.
  - Breaks are never enqueued.
- FIFO: show-ahead, 9-bit entries {ext, code}.
  - Pop when `key_valid` and `key_ready`.
  - Push when full without a simultaneous pop: entry dropped, `overflow` := 1.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push and pop in the same cycle when count=1: head advances to the new entry, count stays 1.
  - `key_ready` with `key_valid`=0 is ignored; no underflow.
- `clear`:
  - Empties the FIFO, FSM -> IDLE, PAUSE counter := 0, held_valid := 0, `overflow` := 0.
  - `clear` beats any push or pop in the same cycle; that cycle's byte is discarded.
- `key_held` = held_valid.

## Timing
- All state is registered.
- Byte strobe at edge N producing an enqueued event: `key_valid`/`key_code` reflect it after edge N (visible cycle N+1) when the FIFO was empty. Latency is 1 cycle.
- Prefix bytes (`E0`/`F0`/`E1`) produce no output. The multi-byte latency is set by PS/2 byte arrival.
- Pop at edge N: the next head (or empty) is visible cycle N+1.
- `fifo_count` and `overflow` update on the same edge as the push or pop.
- Reset (async assert, any state including mid-sequence or mid-PAUSE): `key_valid`=0, `key_code`=0, `key_extended`=0, `key_held`=0, `fifo_count`=0, `overflow`=0, FSM IDLE, counter 0. The first byte after deassert is treated as the start of a new sequence.
- Back-to-back strobes on consecutive cycles are accepted; no minimum spacing is required.

## Test plan
- Bytes `1C`, `F0`, `1C`, no pops -> exactly one event, `key_code`=`1C`, `key_extended`=0. `key_held` 1 after the first byte, 0 after the third. `fifo_count`=1.
- Bytes `1C`, `1C`, `1C`, `F0`, `1C`, `1C` with `REPEAT_SUPPRESS`=1 -> two events, both `1C`. Same stimulus with `REPEAT_SUPPRESS`=0 -> four events.
- Bytes `E0`, `75`, `E0`, `F0`, `75`, then `E1`,`14`,`77`,`E1`,`F0`,`14`,`F0`,`77`, then `AA`, `29` -> events {1,`75`} then {0,`29`} only.
- `FIFO_DEPTH`=4, six distinct makes, `key_ready`=0 -> `fifo_count`=4, `overflow`=1. Pops return the first four codes in order. Then a push and pop in the same cycle while full -> count stays 4.
- Assert `clear` in the same cycle as a make strobe with 3 events queued -> next cycle `fifo_count`=0, `key_valid`=0, `overflow`=0, `key_held`=0.
- Assert `reset` after `E0`,`F0` -> outputs zero. Then byte `75` -> event {0,`75`} (not treated as a break).

Source files
------------

// File: rtl/ps2_keystroke_filter_if.sv
// Key event bus between the PS/2 byte source, the keystroke filter
// and the reader FSM that pops events.
interface ps2_keystroke_filter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          ps2_data_en;
  logic [7:0]    ps2_data;
  logic          clear;
  logic          key_ready;
  logic          key_valid;
  logic [7:0]    key_code;
  logic          key_extended;
  logic          key_held;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output ps2_data_en,
    output ps2_data,
    output clear,
    output key_ready,
    input  key_valid,
    input  key_code,
    input  key_extended,
    input  key_held,
    input  fifo_count,
    input  overflow
  );

  modport slave (
    input  ps2_data_en,
    input  ps2_data,
    input  clear,
    input  key_ready,
    output key_valid,
    output key_code,
    output key_extended,
    output key_held,
    output fifo_count,
    output overflow
  );
endinterface

// File: rtl/ps2_keystroke_filter.sv
// Collapses PS/2 Set-2 scan-code sequences into one event per key
// press and queues them in a small show-ahead FIFO.
module ps2_keystroke_filter #(
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_SUPPRESS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  ps2_keystroke_filter_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, EXT, BRK, EBRK, PAUSE
  } state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_t;

  state_t        st, st_n;
  logic [2:0]    cnt, cnt_n;
  logic          mk, brk;
  key_t          ev;

  logic          held_valid;
  key_t          held;

  key_t          mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] count;
  logic          ovf;

  logic          match, push, pop, full, do_push;

  // Decoder state and Pause skip counter; clear wins over bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= IDLE;
      cnt <= 3'd0;
    end else if (bus.clear) begin
      st  <= IDLE;
      cnt <= 3'd0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

  // Next-state decode of one scan-code byte into make/break events.
  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    mk       = 1'b0;
    brk      = 1'b0;
    ev.ext   = 1'b0;
    ev.code  = bus.ps2_data;
    if (bus.ps2_data_en) begin
      unique case (st)
        IDLE: begin
          case (bus.ps2_data)
            8'hE0: st_n = EXT;
            8'hF0: st_n = BRK;
            8'hE1: begin
              st_n  = PAUSE;
              cnt_n = 3'd7;
            end
            8'h00, 8'hAA, 8'hFA, 8'hFC,
            8'hFD, 8'hFE, 8'hFF: begin
              st_n = IDLE;
            end
            default: mk = 1'b1;
          endcase
        end
        EXT: begin
          st_n   = IDLE;
          ev.ext = 1'b1;
          case (bus.ps2_data)
            8'hF0:        st_n = EBRK;
            8'h12, 8'h59: mk   = 1'b0;
            default:      mk   = 1'b1;
          endcase
        end
        BRK: begin
          st_n = IDLE;
          brk  = 1'b1;
        end
        EBRK: begin
          st_n   = IDLE;
          ev.ext = 1'b1;
          brk    = 1'b1;
        end
        PAUSE: begin
          if (cnt <= 3'd1) begin
            st_n  = IDLE;
            cnt_n = 3'd0;
          end else begin
            cnt_n = cnt - 3'd1;
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  assign match   = held_valid && (held == ev);
  assign push    = mk && !bus.clear &&
                   !((REPEAT_SUPPRESS != 0) && match);
  assign pop     = (count != '0) && bus.key_ready && !bus.clear;
  assign full    = (count == FULL);
  assign do_push = push && (!full || pop);

  // Held key: last pressed key wins, released only by its own break.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_valid <= 1'b0;
      held       <= '0;
    end else if (bus.clear) begin
      held_valid <= 1'b0;
    end else if (push) begin
      held_valid <= 1'b1;
      held       <= ev;
    end else if (brk && match) begin
      held_valid <= 1'b0;
    end
  end

  // FIFO storage; contents are don't-care while not counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= ev;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (bus.clear) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (pop)     rd <= rd + 1'b1;
      if (push && full && !pop) ovf <= 1'b1;
      unique case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.key_valid    = (count != '0);
  assign bus.key_code     = bus.key_valid ? mem[rd].code : 8'h00;
  assign bus.key_extended = bus.key_valid && mem[rd].ext;
  assign bus.key_held     = held_valid;
  assign bus.fifo_count   = count;
  assign bus.overflow     = ovf;
endmodule

// File: tb/tb_ps2_keystroke_filter.sv
// Directed bench for ps2_keystroke_filter: two instances, one with
// repeat suppression and one without, fed the same byte stream.
module tb_ps2_keystroke_filter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [7:0] data = 8'h00;
  logic       clr = 1'b0;
  logic       rdy = 1'b0;
  int         passed = 0;
  int         total = 0;

  always #5 clk = ~clk;

  ps2_keystroke_filter_if #(.FIFO_DEPTH(4)) bs ();
  ps2_keystroke_filter_if #(.FIFO_DEPTH(4)) bn ();

  assign bs.ps2_data_en = en;
  assign bs.ps2_data    = data;
  assign bs.clear       = clr;
  assign bs.key_ready   = rdy;
  assign bn.ps2_data_en = en;
  assign bn.ps2_data    = data;
  assign bn.clear       = clr;
  assign bn.key_ready   = rdy;

  ps2_keystroke_filter #(
    .FIFO_DEPTH(4), .REPEAT_SUPPRESS(1)
  ) dut (.clk(clk), .reset(reset), .bus(bs));

  ps2_keystroke_filter #(
    .FIFO_DEPTH(4), .REPEAT_SUPPRESS(0)
  ) dut_nr (.clk(clk), .reset(reset), .bus(bn));

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    en = 1'b1;
    data = b;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic pop1();
    @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (bs.key_valid !== 1'b0)
      $display("FAIL rst_valid: got %b want 0", bs.key_valid);
    else passed++;
    total++;
    if (bs.key_code !== 8'h00)
      $display("FAIL rst_code: got %h want 00", bs.key_code);
    else passed++;
    total++;
    if (bs.fifo_count !== 3'd0)
      $display("FAIL rst_count: got %0d want 0", bs.fifo_count);
    else passed++;
    total++;
    if ({bs.key_held, bs.overflow, bs.key_extended} !== 3'b000)
      $display("FAIL rst_flags: got %b want 000",
               {bs.key_held, bs.overflow, bs.key_extended});
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_clear();
    send(8'h1C);
    total++;
    if (bs.key_held !== 1'b1)
      $display("FAIL basic_held1: got %b want 1", bs.key_held);
    else passed++;
    total++;
    if (bs.key_valid !== 1'b1 || bs.key_code !== 8'h1C)
      $display("FAIL basic_head: got %b/%h want 1/1c",
               bs.key_valid, bs.key_code);
    else passed++;
    send(8'hF0);
    send(8'h1C);
    total++;
    if (bs.key_held !== 1'b0)
      $display("FAIL basic_held0: got %b want 0", bs.key_held);
    else passed++;
    total++;
    if (bs.fifo_count !== 3'd1)
      $display("FAIL basic_count: got %0d want 1", bs.fifo_count);
    else passed++;
    total++;
    if (bs.key_code !== 8'h1C || bs.key_extended !== 1'b0)
      $display("FAIL basic_event: got %b/%h want 0/1c",
               bs.key_extended, bs.key_code);
    else passed++;
    pop1();
    total++;
    if (bs.key_valid !== 1'b0 || bs.key_code !== 8'h00)
      $display("FAIL basic_pop: got %b/%h want 0/00",
               bs.key_valid, bs.key_code);
    else passed++;
  endtask

  task automatic test_repeat();
    logic [7:0] s [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
    do_clear();
    for (int i = 0; i < 6; i++) send(s[i]);
    total++;
    if (bs.fifo_count !== 3'd2)
      $display("FAIL rep_sup_count: got %0d want 2", bs.fifo_count);
    else passed++;
    total++;
    if (bn.fifo_count !== 3'd4 || bn.overflow !== 1'b0)
      $display("FAIL rep_all_count: got %0d/%b want 4/0",
               bn.fifo_count, bn.overflow);
    else passed++;
    pop1();
    total++;
    if (bs.key_code !== 8'h1C || bs.fifo_count !== 3'd1)
      $display("FAIL rep_second: got %h/%0d want 1c/1",
               bs.key_code, bs.fifo_count);
    else passed++;
  endtask

  task automatic test_ext_pause();
    logic [7:0] s [15] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75,
                           8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0,
                           8'h14, 8'hF0, 8'h77, 8'hAA, 8'h29};
    do_clear();
    for (int i = 0; i < 15; i++) send(s[i]);
    total++;
    if (bs.fifo_count !== 3'd2)
      $display("FAIL ext_count: got %0d want 2", bs.fifo_count);
    else passed++;
    total++;
    if (bs.key_extended !== 1'b1 || bs.key_code !== 8'h75)
      $display("FAIL ext_first: got %b/%h want 1/75",
               bs.key_extended, bs.key_code);
    else passed++;
    pop1();
    total++;
    if (bs.key_extended !== 1'b0 || bs.key_code !== 8'h29)
      $display("FAIL ext_second: got %b/%h want 0/29",
               bs.key_extended, bs.key_code);
    else passed++;
    pop1();
    send(8'hE0);
    send(8'h12);
    send(8'hFA);
    total++;
    if (bs.fifo_count !== 3'd0)
      $display("FAIL ext_fake_shift: got %0d want 0", bs.fifo_count);
    else passed++;
    @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    total++;
    if (bs.fifo_count !== 3'd0 || bs.key_valid !== 1'b0)
      $display("FAIL underflow: got %0d/%b want 0/0",
               bs.fifo_count, bs.key_valid);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [7:0] s [6] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
    logic [7:0] r [4] = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
    do_clear();
    for (int i = 0; i < 6; i++) send(s[i]);
    total++;
    if (bs.fifo_count !== 3'd4 || bs.overflow !== 1'b1)
      $display("FAIL ovf_state: got %0d/%b want 4/1",
               bs.fifo_count, bs.overflow);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bs.key_code !== s[i])
        $display("FAIL ovf_order%0d: got %h want %h",
                 i, bs.key_code, s[i]);
      else passed++;
      pop1();
    end
    for (int i = 0; i < 4; i++) send(r[i]);
    @(negedge clk);
    en = 1'b1;
    data = 8'h34;
    rdy = 1'b1;
    @(negedge clk);
    en = 1'b0;
    rdy = 1'b0;
    total++;
    if (bs.fifo_count !== 3'd4 || bs.key_code !== 8'h1B)
      $display("FAIL full_pushpop: got %0d/%h want 4/1b",
               bs.fifo_count, bs.key_code);
    else passed++;
    total++;
    if (bs.overflow !== 1'b1)
      $display("FAIL ovf_sticky: got %b want 1", bs.overflow);
    else passed++;
  endtask

  task automatic test_clear();
    pop1();
    @(negedge clk);
    en = 1'b1;
    data = 8'h44;
    clr = 1'b1;
    @(negedge clk);
    en = 1'b0;
    clr = 1'b0;
    total++;
    if (bs.fifo_count !== 3'd0 || bs.key_valid !== 1'b0)
      $display("FAIL clr_fifo: got %0d/%b want 0/0",
               bs.fifo_count, bs.key_valid);
    else passed++;
    total++;
    if (bs.overflow !== 1'b0 || bs.key_held !== 1'b0)
      $display("FAIL clr_flags: got %b/%b want 0/0",
               bs.overflow, bs.key_held);
    else passed++;
    send(8'h1C);
    @(negedge clk);
    en = 1'b1;
    data = 8'h1B;
    rdy = 1'b1;
    @(negedge clk);
    en = 1'b0;
    rdy = 1'b0;
    total++;
    if (bs.fifo_count !== 3'd1 || bs.key_code !== 8'h1B)
      $display("FAIL one_pushpop: got %0d/%h want 1/1b",
               bs.fifo_count, bs.key_code);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] s [4] = '{8'h1C, 8'hF0, 8'h1C, 8'h32};
    do_clear();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en = 1'b1;
      data = s[i];
    end
    @(negedge clk);
    en = 1'b0;
    total++;
    if (bs.fifo_count !== 3'd2 || bs.key_code !== 8'h1C)
      $display("FAIL b2b_queue: got %0d/%h want 2/1c",
               bs.fifo_count, bs.key_code);
    else passed++;
    total++;
    if (bs.key_held !== 1'b1)
      $display("FAIL b2b_held: got %b want 1", bs.key_held);
    else passed++;
  endtask

  task automatic test_reset_mid();
    send(8'hE0);
    send(8'hF0);
    #2 reset = 1'b1;
    #1;
    total++;
    if (bs.key_valid !== 1'b0 || bs.fifo_count !== 3'd0 ||
        bs.key_code !== 8'h00 || bs.key_held !== 1'b0)
      $display("FAIL rstmid_out: got %b/%0d/%h/%b want 0/0/00/0",
               bs.key_valid, bs.fifo_count, bs.key_code, bs.key_held);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    send(8'h75);
    total++;
    if (bs.fifo_count !== 3'd1 || bs.key_code !== 8'h75 ||
        bs.key_extended !== 1'b0)
      $display("FAIL rstmid_make: got %0d/%b/%h want 1/0/75",
               bs.fifo_count, bs.key_extended, bs.key_code);
    else passed++;
    send(8'hE1);
    send(8'h14);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(8'h29);
    total++;
    if (bs.fifo_count !== 3'd1 || bs.key_code !== 8'h29)
      $display("FAIL rstpause_make: got %0d/%h want 1/29",
               bs.fifo_count, bs.key_code);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_ext_pause();
    test_overflow();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
